bit_serializer: RTL and testbench

- Upstream feed stage for the 1101 sequence detector.
- Accepts parallel words over a valid/ready handshake and emits them one bit per clock on a registered serial output.
- The serial output drives the detector's `in` port directly. The detector samples every clock, so this block always drives a defined level, including when idle.
- Supports gapless back-to-back words, so a pattern can straddle a word boundary.

---
 rtl/bit_serializer_pkg.sv | 17 +
 rtl/bit_serializer.sv | 116 +++++++++++
 tb/tb_bit_serializer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/bit_serializer_pkg.sv
// Shared types and constants for the bit serializer feeding the 1101 sequence detector.
package bit_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int unsigned DET_W = 4;
  localparam logic [DET_W-1:0] DET_PATTERN = 4'b1101;

  // Bit-counter width for a given word width (never below 1 bit).
  function automatic int unsigned cnt_width(input int unsigned data_w);
    return (data_w < 2) ? 1 : $clog2(data_w);
  endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial feed stage: valid/ready word intake, one registered bit per clock,
// gapless back-to-back words, defined idle level when nothing is being shifted.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter logic        IDLE_BIT  = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              frame_start,
  output logic              frame_end,
  output logic [15:0]       words_sent
);

  localparam int unsigned CNT_W = cnt_width(DATA_W);

  state_t              state, state_nx;
  logic [DATA_W-1:0]   sreg, sreg_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic                bit_out_nx, bit_valid_nx, frame_start_nx, frame_end_nx;

  logic                last_bit;
  logic                accept;
  logic                load_bit;
  logic [DATA_W-1:0]   load_rest;
  logic                shift_bit;
  logic [DATA_W-1:0]   shift_rest;

  assign last_bit  = (state == SHIFT) && (cnt == CNT_W'(DATA_W - 1));
  assign din_ready = (state == IDLE) || last_bit;
  assign accept    = din_valid && din_ready;

  // Bit ordering: sreg always presents the next outgoing bit at the shift end.
  assign load_bit   = MSB_FIRST ? din[DATA_W-1] : din[0];
  assign load_rest  = MSB_FIRST ? {din[DATA_W-2:0], 1'b0} : {1'b0, din[DATA_W-1:1]};
  assign shift_bit  = MSB_FIRST ? sreg[DATA_W-1] : sreg[0];
  assign shift_rest = MSB_FIRST ? {sreg[DATA_W-2:0], 1'b0} : {1'b0, sreg[DATA_W-1:1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      sreg        <= '0;
      cnt         <= '0;
      bit_out     <= IDLE_BIT;
      bit_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
    end else begin
      state       <= state_nx;
      sreg        <= sreg_nx;
      cnt         <= cnt_nx;
      bit_out     <= bit_out_nx;
      bit_valid   <= bit_valid_nx;
      frame_start <= frame_start_nx;
      frame_end   <= frame_end_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    sreg_nx        = sreg;
    cnt_nx         = cnt;
    bit_out_nx     = IDLE_BIT;
    bit_valid_nx   = 1'b0;
    frame_start_nx = 1'b0;
    frame_end_nx   = 1'b0;

    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nx       = SHIFT;
          cnt_nx         = '0;
          sreg_nx        = load_rest;
          bit_out_nx     = load_bit;
          bit_valid_nx   = 1'b1;
          frame_start_nx = 1'b1;
        end
      end
      SHIFT: begin
        if (!last_bit) begin
          cnt_nx       = cnt + CNT_W'(1);
          sreg_nx      = shift_rest;
          bit_out_nx   = shift_bit;
          bit_valid_nx = 1'b1;
          frame_end_nx = (cnt == CNT_W'(DATA_W - 2));
        end else if (accept) begin
          // Reload straight from the last bit: no idle fill between words.
          cnt_nx         = '0;
          sreg_nx        = load_rest;
          bit_out_nx     = load_bit;
          bit_valid_nx   = 1'b1;
          frame_start_nx = 1'b1;
        end else begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      words_sent <= '0;
    end else if (last_bit) begin
      words_sent <= words_sent + 16'd1;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench: MSB-first and LSB-first instances share stimulus; expected bits are
// queued on every accepted word and compared as the serial stream comes out.
`timescale 1ns/1ps
module tb_bit_serializer;
  import bit_serializer_pkg::*;

  typedef struct {
    logic b;
    logic first;
    logic last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  din;
  logic        din_valid;

  logic        ready_m, bit_m, valid_m, fs_m, fe_m;
  logic [15:0] words_m;
  logic        ready_l, bit_l, valid_l, fs_l, fe_l;
  logic [15:0] words_l;

  exp_t        qm[$];
  exp_t        ql[$];
  int          wexp_m = 0;
  int          wexp_l = 0;
  logic [3:0]  hist_m = '0;
  int          hits_m = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  bit_serializer #(.DATA_W(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(ready_m),
    .bit_out(bit_m), .bit_valid(valid_m), .frame_start(fs_m), .frame_end(fe_m),
    .words_sent(words_m)
  );

  bit_serializer #(.DATA_W(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(ready_l),
    .bit_out(bit_l), .bit_valid(valid_l), .frame_start(fs_l), .frame_end(fe_l),
    .words_sent(words_l)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      qm.push_back('{b: w[7-i], first: (i == 0), last: (i == 7)});
      ql.push_back('{b: w[i],   first: (i == 0), last: (i == 7)});
    end
  endtask

  // Offer a word, wait (bounded) for ready, push expectations on the accepting edge.
  task automatic send_word(input logic [7:0] w, input bit keep, output int waited);
    din       = w;
    din_valid = 1'b1;
    waited    = 0;
    @(negedge clk);
    while (!ready_m && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    check("accept", 32'(ready_m), 32'd1);
    @(posedge clk);
    push_word(w);
    #1;
    if (!keep) din_valid = 1'b0;
  endtask

  // Scoreboard monitor plus reference 1101 detector on the MSB-first stream.
  always @(negedge clk) begin
    exp_t e;
    check("ready_m", 32'(ready_m), 32'(qm.size() <= 1));
    check("valid_m", 32'(valid_m), 32'(qm.size() != 0));
    check("words_m", 32'(words_m), 32'(wexp_m));
    if (qm.size() != 0) begin
      e = qm.pop_front();
      check("bit_m", 32'(bit_m), 32'(e.b));
      check("fs_m", 32'(fs_m), 32'(e.first));
      check("fe_m", 32'(fe_m), 32'(e.last));
      if (e.last) wexp_m++;
    end else begin
      check("idle_m", 32'({bit_m, fs_m, fe_m}), 32'd0);
    end
    check("ready_l", 32'(ready_l), 32'(ql.size() <= 1));
    check("valid_l", 32'(valid_l), 32'(ql.size() != 0));
    check("words_l", 32'(words_l), 32'(wexp_l));
    if (ql.size() != 0) begin
      e = ql.pop_front();
      check("bit_l", 32'(bit_l), 32'(e.b));
      check("fs_l", 32'(fs_l), 32'(e.first));
      check("fe_l", 32'(fe_l), 32'(e.last));
      if (e.last) wexp_l++;
    end else begin
      check("idle_l", 32'({bit_l, fs_l, fe_l}), 32'd0);
    end
    hist_m = {hist_m[2:0], bit_m};
    if (hist_m == DET_PATTERN) hits_m++;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    int hits0;
    rst       = 1'b0;
    din       = '0;
    din_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_bit", 32'(bit_m), 32'd0);
    check("rst_valid", 32'(valid_m), 32'd0);
    check("rst_frame", 32'({fs_m, fe_m}), 32'd0);
    check("rst_words", 32'(words_m), 32'd0);
    check("rst_ready", 32'(ready_m), 32'd1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single word 0x0D: detector fires once on the final bit.
    hits0 = hits_m;
    send_word(8'h0D, 1'b0, waited);
    check("single_lat", 32'({valid_m, fs_m, bit_m}), 32'b110);
    repeat (12) @(posedge clk);
    #1;
    check("single_hits", 32'(hits_m - hits0), 32'd1);
    check("single_words", 32'(words_m), 32'd1);

    // Back-to-back 0xB0, 0x0B with valid held: no 1101 in this stream.
    hits0 = hits_m;
    send_word(8'hB0, 1'b1, waited);
    send_word(8'h0B, 1'b0, waited);
    check("b2b_wait", 32'(waited), 32'd7);
    repeat (12) @(posedge clk);
    #1;
    check("b2b_hits", 32'(hits_m - hits0), 32'd0);
    check("b2b_words", 32'(words_m), 32'd3);

    // 0x01 then 0xA0: the 1101 straddles the word boundary.
    hits0 = hits_m;
    send_word(8'h01, 1'b1, waited);
    send_word(8'hA0, 1'b0, waited);
    repeat (12) @(posedge clk);
    #1;
    check("straddle_hits", 32'(hits_m - hits0), 32'd1);

    // Stall: word offered at cnt=3 waits until the last bit of the current word.
    send_word(8'hAA, 1'b0, waited);
    repeat (3) @(posedge clk);
    #1;
    din       = 8'hFF;
    din_valid = 1'b1;
    #1;
    check("stall_ready", 32'(ready_m), 32'd0);
    send_word(8'hFF, 1'b0, waited);
    check("stall_wait", 32'(waited), 32'd4);
    repeat (12) @(posedge clk);
    #1;

    // Asynchronous reset at cnt=4 of a word.
    send_word(8'h5A, 1'b0, waited);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b0;
    qm.delete();
    ql.delete();
    wexp_m = 0;
    wexp_l = 0;
    #1;
    check("arst_bit", 32'(bit_m), 32'd0);
    check("arst_valid", 32'(valid_m), 32'd0);
    check("arst_words", 32'(words_m), 32'd0);
    check("arst_lsb_valid", 32'(valid_l), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    send_word(8'h96, 1'b0, waited);
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_words", 32'(words_m), 32'd1);

    // LSB-first 0x0B: stream 1,1,0,1,0,0,0,0 is checked by the scoreboard.
    send_word(8'h0B, 1'b0, waited);
    check("lsb_first_bit", 32'(bit_l), 32'd1);
    repeat (10) @(posedge clk);
    #1;

    // Idle fill for 20 cycles.
    hits0 = hits_m;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_fill", 32'({bit_m, valid_m}), 32'd0);
    end
    check("idle_hits", 32'(hits_m - hits0), 32'd0);
    check("q_empty", 32'(qm.size() + ql.size()), 32'd0);
    check("final_words_l", 32'(words_l), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
